starbug_regfile: RTL and testbench



---
 rtl/starbug_regfile_pkg.sv | 14 +
 rtl/starbug_regfile_if.sv | 26 ++
 rtl/starbug_regfile_wq.sv | 90 +++++++++
 rtl/starbug_regfile.sv | 114 +++++++++++
 tb/tb_starbug_regfile.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/starbug_regfile_pkg.sv
// Shared types and constants for the STARBUG integer register file.
package starbug_regfile_pkg;

  localparam int STARBUG_XLEN  = 64;
  localparam int STARBUG_LANES = 2;
  localparam int STARBUG_AW    = 5;

  // One pending write held in the write queue.
  typedef struct packed {
    logic [STARBUG_AW-1:0]   adr;
    logic [STARBUG_XLEN-1:0] data;
  } starbug_wq_entry_t;

endpackage

// File: rtl/starbug_regfile_if.sv
// Per-lane regfile bus between the IEU datapaths (master) and the regfile (slave).
interface starbug_regfile_if
  import starbug_regfile_pkg::*;
#(
  parameter int LANES = STARBUG_LANES
);
  logic [LANES-1:0]                       we3;
  logic [LANES-1:0][STARBUG_AW-1:0]       a1;
  logic [LANES-1:0][STARBUG_AW-1:0]       a2;
  logic [LANES-1:0][STARBUG_AW-1:0]       a3;
  logic [LANES-1:0][STARBUG_XLEN-1:0]     wd3;
  logic [LANES-1:0][STARBUG_XLEN-1:0]     rd1;
  logic [LANES-1:0][STARBUG_XLEN-1:0]     rd2;
  logic                                   WqReadyW;
  logic                                   WqEmpty;

  modport master (
    output we3, a1, a2, a3, wd3,
    input  rd1, rd2, WqReadyW, WqEmpty
  );

  modport slave (
    input  we3, a1, a2, a3, wd3,
    output rd1, rd2, WqReadyW, WqEmpty
  );
endinterface

// File: rtl/starbug_regfile_wq.sv
// Circular write queue: up to LANES pushes per cycle in lane order, one pop per
// cycle from the head, and a youngest-match lookup for every read port.
module starbug_wq
  import starbug_regfile_pkg::*;
#(
  parameter int LANES    = STARBUG_LANES,
  parameter int WQ_DEPTH = 4,
  parameter int NRD      = 2 * LANES,
  parameter int CW       = $clog2(WQ_DEPTH + 1)
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic              [LANES-1:0]       enq_vld,
  input  starbug_wq_entry_t [LANES-1:0]       enq_ent,
  output logic                                head_vld,
  output starbug_wq_entry_t                   head_ent,
  output logic              [CW-1:0]          count,
  input  logic [NRD-1:0][STARBUG_AW-1:0]      lk_adr,
  output logic [NRD-1:0]                      lk_hit,
  output logic [NRD-1:0][STARBUG_XLEN-1:0]    lk_data
);

  localparam int PW = (WQ_DEPTH > 1) ? $clog2(WQ_DEPTH) : 1;

  starbug_wq_entry_t [WQ_DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  function automatic logic [PW-1:0] wrap(input int p);
    return PW'(p % WQ_DEPTH);
  endfunction

  assign head_vld = (count_q != '0);
  assign head_ent = mem_q[head_q];
  assign count    = count_q;

  // Enqueue valid lanes at consecutive tail slots, pop the head whenever non-empty.
  always_comb begin
    int n;
    int cnt;
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    n       = 0;
    for (int i = 0; i < LANES; i++) begin
      if (enq_vld[i]) begin
        mem_d[wrap(int'(tail_q) + n)] = enq_ent[i];
        n = n + 1;
      end
    end
    tail_d = wrap(int'(tail_q) + n);
    if (head_vld) head_d = wrap(int'(head_q) + 1);
    cnt     = int'(count_q) + n - (head_vld ? 1 : 0);
    count_d = (cnt > WQ_DEPTH) ? CW'(WQ_DEPTH) : CW'(cnt);
  end

  // Walk live entries oldest to youngest so the last hit is the youngest match.
  always_comb begin
    starbug_wq_entry_t e;
    e       = '0;
    lk_hit  = '0;
    lk_data = '0;
    for (int r = 0; r < NRD; r++) begin
      for (int k = 0; k < WQ_DEPTH; k++) begin
        e = mem_q[wrap(int'(head_q) + k)];
        if (k < int'(count_q) && e.adr == lk_adr[r]) begin
          lk_hit[r]  = 1'b1;
          lk_data[r] = e.data;
        end
      end
    end
  end

  // Queue state registers; reset discards everything pending.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/starbug_regfile.sv
// Shared multi-lane integer register file: accepts up to LANES writes per cycle,
// commits one per cycle through a write queue, and forwards pending writes to
// every read port so all lanes observe write-first behaviour.
module starbug_regfile
  import starbug_regfile_pkg::*;
#(
  parameter int LANES    = STARBUG_LANES,
  parameter int NREGS    = 32,
  parameter int WQ_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  starbug_regfile_if.slave rf
);

  localparam int XLEN = STARBUG_XLEN;
  localparam int NRD  = 2 * LANES;
  localparam int CW   = $clog2(WQ_DEPTH + 1);
  localparam int IW   = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [NREGS-1:0][XLEN-1:0]       regs_q, regs_d;
  logic [LANES-1:0]                 wr_vld, enq_vld;
  starbug_wq_entry_t [LANES-1:0]    wr_ent;
  logic                             direct;
  logic                             head_vld;
  starbug_wq_entry_t                head_ent;
  logic [CW-1:0]                    count;
  logic [NRD-1:0][STARBUG_AW-1:0]   lk_adr;
  logic [NRD-1:0]                   lk_hit;
  logic [NRD-1:0][XLEN-1:0]         lk_data;
  logic [NRD-1:0][XLEN-1:0]         rd_data;

  // Ready depends on the registered count only, so W-stage stall has no path from we3.
  assign rf.WqReadyW = (WQ_DEPTH - int'(count)) >= LANES;
  assign rf.WqEmpty  = (count == '0);

  // Read ports are flattened as {a2,a1} per lane for the queue lookup and the muxes.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign lk_adr[2*i]   = rf.a1[i];
    assign lk_adr[2*i+1] = rf.a2[i];
    assign rf.rd1[i]     = rd_data[2*i];
    assign rf.rd2[i]     = rd_data[2*i+1];
  end

  // Write filter; a lone write into an empty queue bypasses it and goes straight to the array.
  always_comb begin
    int nv;
    nv     = 0;
    wr_vld = '0;
    wr_ent = '0;
    for (int i = 0; i < LANES; i++) begin
      wr_ent[i].adr  = rf.a3[i];
      wr_ent[i].data = rf.wd3[i];
      wr_vld[i]      = rf.we3[i] && (rf.a3[i] != '0) && (int'(rf.a3[i]) < NREGS)
                       && rf.WqReadyW;
      if (wr_vld[i]) nv = nv + 1;
    end
    direct  = (count == '0) && (nv == 1);
    enq_vld = direct ? '0 : wr_vld;
  end

  starbug_wq #(
    .LANES    (LANES),
    .WQ_DEPTH (WQ_DEPTH),
    .NRD      (NRD),
    .CW       (CW)
  ) u_wq (
    .clk      (clk),
    .reset_n  (reset_n),
    .enq_vld  (enq_vld),
    .enq_ent  (wr_ent),
    .head_vld (head_vld),
    .head_ent (head_ent),
    .count    (count),
    .lk_adr   (lk_adr),
    .lk_hit   (lk_hit),
    .lk_data  (lk_data)
  );

  // One array write per cycle: queue head when draining, otherwise the direct write.
  always_comb begin
    regs_d = regs_q;
    if (head_vld) begin
      regs_d[head_ent.adr[IW-1:0]] = head_ent.data;
    end else if (direct) begin
      for (int i = 0; i < LANES; i++)
        if (wr_vld[i]) regs_d[wr_ent[i].adr[IW-1:0]] = wr_ent[i].data;
    end
  end

  // Read priority: x0/out-of-range, then youngest incoming write, then queue, then array.
  always_comb begin
    rd_data = '0;
    for (int r = 0; r < NRD; r++) begin
      rd_data[r] = regs_q[lk_adr[r][IW-1:0]];
      if (lk_hit[r]) rd_data[r] = lk_data[r];
      for (int j = 0; j < LANES; j++)
        if (wr_vld[j] && wr_ent[j].adr == lk_adr[r]) rd_data[r] = wr_ent[j].data;
      if (lk_adr[r] == '0 || int'(lk_adr[r]) >= NREGS) rd_data[r] = '0;
    end
  end

  // Architectural register array.
  always_ff @(posedge clk) begin
    if (!reset_n) regs_q <= '0;
    else          regs_q <= regs_d;
  end

  // Writing while not ready breaks the hazard-unit contract; such writes are dropped.
  a_no_write_when_full : assert property (
    @(posedge clk) disable iff (!reset_n) !((|rf.we3) && !rf.WqReadyW)
  );

endmodule

// File: tb/tb_starbug_regfile.sv
module tb_starbug_regfile;
  import starbug_regfile_pkg::*;

  localparam int L  = 2;
  localparam int NV = 21;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  starbug_regfile_if #(.LANES(L)) rf_if ();
  starbug_regfile_if #(.LANES(L)) rf16_if ();

  starbug_regfile #(.LANES(L), .NREGS(32), .WQ_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .rf(rf_if.slave)
  );
  starbug_regfile #(.LANES(L), .NREGS(16), .WQ_DEPTH(4)) dut16 (
    .clk(clk), .reset_n(reset_n), .rf(rf16_if.slave)
  );

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  a3_0, a3_1;
    logic [63:0] wd_0, wd_1;
    logic [4:0]  a1_0, a2_0, a1_1, a2_1;
    logic [63:0] e1_0, e2_0, e1_1, e2_1;
    logic        erdy, eemp;
  } vec_t;

  vec_t tbl [NV];
  vec_t exp_q [$];
  int n_vec = 0;
  int n_bad = 0;

  function automatic vec_t mk(int we, int a30, logic [63:0] w0, int a31, logic [63:0] w1,
                              int r10, int r20, int r11, int r21,
                              logic [63:0] e10, logic [63:0] e20, logic [63:0] e11,
                              logic [63:0] e21, int rdy, int emp);
    vec_t v;
    v.we = 2'(we); v.a3_0 = 5'(a30); v.wd_0 = w0; v.a3_1 = 5'(a31); v.wd_1 = w1;
    v.a1_0 = 5'(r10); v.a2_0 = 5'(r20); v.a1_1 = 5'(r11); v.a2_1 = 5'(r21);
    v.e1_0 = e10; v.e2_0 = e20; v.e1_1 = e11; v.e2_1 = e21;
    v.erdy = 1'(rdy); v.eemp = 1'(emp);
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(vec_t v);
    rf_if.we3   = v.we;
    rf_if.a3[0] = v.a3_0; rf_if.wd3[0] = v.wd_0;
    rf_if.a3[1] = v.a3_1; rf_if.wd3[1] = v.wd_1;
    rf_if.a1[0] = v.a1_0; rf_if.a2[0] = v.a2_0;
    rf_if.a1[1] = v.a1_1; rf_if.a2[1] = v.a2_1;
  endtask

  task automatic idle16();
    rf16_if.we3 = '0; rf16_if.a3 = '0; rf16_if.wd3 = '0; rf16_if.a1 = '0; rf16_if.a2 = '0;
  endtask

  task automatic chk_state(string nm, logic erdy, logic eemp);
    chk({nm, " WqReadyW"}, 64'(rf_if.WqReadyW), 64'(erdy));
    chk({nm, " WqEmpty"},  64'(rf_if.WqEmpty),  64'(eemp));
  endtask

  initial begin
    vec_t got;
    // Direct path: single write into empty queue, bypassed and then in the array.
    tbl[0]  = mk(1, 5, 'hDEAD, 0, 0,    5, 0, 5, 0,  'hDEAD, 0, 'hDEAD, 0, 1, 1);
    tbl[1]  = mk(0, 0, 0, 0, 0,         5, 0, 5, 0,  'hDEAD, 0, 'hDEAD, 0, 1, 1);
    // Same register from both lanes: lane 1 wins, two-cycle drain.
    tbl[2]  = mk(3, 7, 'h1, 7, 'h2,     7, 5, 5, 7,  'h2, 'hDEAD, 'hDEAD, 'h2, 1, 1);
    tbl[3]  = mk(0, 0, 0, 0, 0,         7, 0, 7, 5,  'h2, 0, 'h2, 'hDEAD, 1, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0,         7, 0, 7, 5,  'h2, 0, 'h2, 'hDEAD, 1, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0,         7, 0, 7, 5,  'h2, 0, 'h2, 'hDEAD, 1, 1);
    // Back-to-back dual writes: count 2 then 3, ready drops, drains one per cycle.
    tbl[6]  = mk(3, 1, 'h11, 2, 'h22,   1, 2, 7, 5,  'h11, 'h22, 'h2, 'hDEAD, 1, 1);
    tbl[7]  = mk(3, 3, 'h33, 4, 'h44,   1, 2, 3, 4,  'h11, 'h22, 'h33, 'h44, 1, 0);
    tbl[8]  = mk(0, 0, 0, 0, 0,         1, 2, 3, 4,  'h11, 'h22, 'h33, 'h44, 0, 0);
    tbl[9]  = mk(0, 0, 0, 0, 0,         1, 2, 3, 4,  'h11, 'h22, 'h33, 'h44, 1, 0);
    tbl[10] = mk(0, 0, 0, 0, 0,         1, 2, 3, 4,  'h11, 'h22, 'h33, 'h44, 1, 0);
    tbl[11] = mk(0, 0, 0, 0, 0,         1, 2, 3, 4,  'h11, 'h22, 'h33, 'h44, 1, 1);
    // Writes to x0 are dropped; x0 always reads 0.
    tbl[12] = mk(1, 0, 'hFFFF, 0, 0,    0, 1, 0, 4,  0, 'h11, 0, 'h44, 1, 1);
    tbl[13] = mk(0, 0, 0, 0, 0,         0, 1, 2, 3,  0, 'h11, 'h22, 'h33, 1, 1);
    // One dropped lane plus one valid lane is still a direct write.
    tbl[14] = mk(3, 0, 'h77, 9, 'h99,   9, 0, 9, 4,  'h99, 0, 'h99, 'h44, 1, 1);
    tbl[15] = mk(0, 0, 0, 0, 0,         9, 2, 9, 4,  'h99, 'h22, 'h99, 'h44, 1, 1);
    // Incoming beats queue, queue beats array, younger queue entry beats older.
    tbl[16] = mk(3, 8, 'h80, 9, 'h90,   8, 9, 8, 9,  'h80, 'h90, 'h80, 'h90, 1, 1);
    tbl[17] = mk(1, 8, 'h81, 0, 0,      8, 9, 8, 1,  'h81, 'h90, 'h81, 'h11, 1, 0);
    tbl[18] = mk(0, 0, 0, 0, 0,         8, 9, 8, 1,  'h81, 'h90, 'h81, 'h11, 1, 0);
    tbl[19] = mk(0, 0, 0, 0, 0,         8, 9, 8, 1,  'h81, 'h90, 'h81, 'h11, 1, 0);
    tbl[20] = mk(0, 0, 0, 0, 0,         8, 9, 8, 1,  'h81, 'h90, 'h81, 'h11, 1, 1);

    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    idle16();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset state: every register reads 0 on every port.
    for (int r = 1; r < 32; r++) begin
      if (r > 1) begin @(posedge clk); #1; end
      rf_if.a1 = {5'(r), 5'(r)};
      rf_if.a2 = {5'(r), 5'(r)};
      @(negedge clk);
      for (int l = 0; l < L; l++) begin
        chk($sformatf("reset x%0d rd1[%0d]", r, l), rf_if.rd1[l], 64'h0);
        chk($sformatf("reset x%0d rd2[%0d]", r, l), rf_if.rd2[l], 64'h0);
      end
      if (r == 1) chk_state("reset", 1'b1, 1'b1);
    end

    // NREGS=16 instance: out-of-range writes dropped and out-of-range reads return 0.
    @(posedge clk); #1;
    rf16_if.we3 = 2'b01; rf16_if.a3[0] = 5'd20; rf16_if.wd3[0] = 64'h55;
    rf16_if.a1[0] = 5'd20;
    @(negedge clk);
    chk("e16 bypass x20", rf16_if.rd1[0], 64'h0);
    @(posedge clk); #1;
    idle16(); rf16_if.a1[0] = 5'd20;
    @(negedge clk);
    chk("e16 read x20", rf16_if.rd1[0], 64'h0);
    chk("e16 empty", 64'(rf16_if.WqEmpty), 64'h1);
    @(posedge clk); #1;
    rf16_if.we3 = 2'b11; rf16_if.a3[0] = 5'd15; rf16_if.wd3[0] = 64'h15;
    rf16_if.a3[1] = 5'd31; rf16_if.wd3[1] = 64'h31;
    rf16_if.a1[0] = 5'd15; rf16_if.a2[1] = 5'd31;
    @(negedge clk);
    chk("e16 bypass x15", rf16_if.rd1[0], 64'h15);
    chk("e16 bypass x31", rf16_if.rd2[1], 64'h0);
    @(posedge clk); #1;
    idle16(); rf16_if.a1[0] = 5'd15; rf16_if.a2[1] = 5'd31;
    @(negedge clk);
    chk("e16 array x15", rf16_if.rd1[0], 64'h15);
    chk("e16 array x31", rf16_if.rd2[1], 64'h0);
    chk("e16 direct empty", 64'(rf16_if.WqEmpty), 64'h1);

    // Table vectors through the scoreboard.
    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      apply(tbl[i]);
      exp_q.push_back(tbl[i]);
      @(negedge clk);
      got = exp_q.pop_front();
      chk($sformatf("v%0d rd1[0]", i), rf_if.rd1[0], got.e1_0);
      chk($sformatf("v%0d rd2[0]", i), rf_if.rd2[0], got.e2_0);
      chk($sformatf("v%0d rd1[1]", i), rf_if.rd1[1], got.e1_1);
      chk($sformatf("v%0d rd2[1]", i), rf_if.rd2[1], got.e2_1);
      chk_state($sformatf("v%0d", i), got.erdy, got.eemp);
    end

    // Reset in the middle of a drain discards pending writes and the array.
    @(posedge clk); #1;
    apply(mk(3, 10, 'hA, 11, 'hB, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    apply(mk(3, 12, 'hC, 13, 'hD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    apply(mk(0, 0, 0, 0, 0, 10, 11, 12, 13, 0, 0, 0, 0, 0, 0));
    reset_n = 1'b0;
    @(negedge clk);
    chk_state("pre-reset", 1'b0, 1'b0);
    chk("pre-reset x13", rf_if.rd2[1], 64'hD);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("mid x10", rf_if.rd1[0], 64'h0);
    chk("mid x11", rf_if.rd2[0], 64'h0);
    chk("mid x12", rf_if.rd1[1], 64'h0);
    chk("mid x13", rf_if.rd2[1], 64'h0);
    chk_state("mid reset", 1'b1, 1'b1);
    @(posedge clk); #1;
    apply(mk(0, 0, 0, 0, 0, 5, 7, 1, 8, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("mid x5", rf_if.rd1[0], 64'h0);
    chk("mid x7", rf_if.rd2[0], 64'h0);
    chk("mid x1", rf_if.rd1[1], 64'h0);
    chk("mid x8", rf_if.rd2[1], 64'h0);
    chk_state("after reset", 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
